// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory/stack stage.
package mem_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PUSH_SEQ = 2'd1,
        ST_POP_SEQ  = 2'd2
    } state_e;

    // Meaning of the stack word moved in a given cycle of an operation.
    typedef enum logic [1:0] {
        W_DATA  = 2'd0,
        W_PC_HI = 2'd1,
        W_PC_LO = 2'd2,
        W_FLAGS = 2'd3
    } word_e;

    // Number of memory words an operation moves.
    function automatic logic [CNT_W-1:0] words_for_op(input mem_op_e op);
        logic [CNT_W-1:0] n;
        case (op)
            OP_LOAD, OP_STORE, OP_PUSH, OP_POP: n = CNT_W'(1);
            OP_CALL, OP_RET:                    n = CNT_W'(2);
            OP_INT, OP_RTI:                     n = CNT_W'(3);
            default:                            n = CNT_W'(0);
        endcase
        return n;
    endfunction

    function automatic logic is_push_op(input mem_op_e op);
        return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    function automatic logic is_pop_op(input mem_op_e op);
        return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
    endfunction

    // Word moved at index idx; pops unwind the push order in reverse.
    function automatic word_e stack_word(input mem_op_e op, input logic [CNT_W-1:0] idx);
        word_e w;
        case (op)
            OP_CALL, OP_INT: w = (idx == CNT_W'(0)) ? W_PC_HI :
                                 (idx == CNT_W'(1)) ? W_PC_LO : W_FLAGS;
            OP_RET:          w = (idx == CNT_W'(0)) ? W_PC_LO : W_PC_HI;
            OP_RTI:          w = (idx == CNT_W'(0)) ? W_FLAGS :
                                 (idx == CNT_W'(1)) ? W_PC_LO : W_PC_HI;
            default:         w = W_DATA;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Data memory: synchronous write, combinational read, contents not reset.
module data_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stack_ctrl.sv
// Memory-stage controller: load/store plus multi-word stack traffic.
module mem_stack_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned       ADDR_W = 11,
    parameter int unsigned       PC_W   = mem_pkg::PC_W,
    parameter logic [ADDR_W-1:0] SP_TOP = ADDR_W'((1 << ADDR_W) - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  mem_op_e           mem_op,
    input  logic [15:0]       alu_result,
    input  logic [15:0]       store_data,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    output logic              stall,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_out_valid,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_out_valid,
    output logic              stack_exc,
    output logic [ADDR_W-1:0] sp
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    mem_op_e             op_q, op_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [PC_W-1:0]     pc_out_q, pc_out_d;
    logic                pc_out_valid_q, pc_out_valid_d;
    logic [FLAG_W-1:0]   flags_out_q, flags_out_d;
    logic                flags_out_valid_q, flags_out_valid_d;
    logic                stack_exc_q, stack_exc_d;
    logic                stall_c;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    mem_op_e             cur_op;
    logic [CNT_W-1:0]    cur_idx;
    logic [PC_W-1:0]     cur_pc;
    logic [FLAG_W-1:0]   cur_flags;
    logic [CNT_W-1:0]    n_words;
    logic [ADDR_W-1:0]   depth;
    logic [ADDR_W-1:0]   mem_addr;
    logic                last_word;
    logic                bound_ok;
    word_e               cur_word;
    logic                unused_alu_hi;

    assign unused_alu_hi = ^alu_result[15:ADDR_W];
    assign mem_addr      = alu_result[ADDR_W-1:0];

    // Operation in flight: a fresh request in IDLE, otherwise the latched sequence.
    always_comb begin
        cur_op    = OP_NOP;
        cur_idx   = '0;
        cur_pc    = pc_in;
        cur_flags = flags_in;
        if (state_q == ST_IDLE) begin
            if (op_valid) begin
                cur_op = mem_op;
            end
        end else begin
            cur_op    = op_q;
            cur_idx   = cnt_q;
            cur_pc    = pc_q;
            cur_flags = flags_q;
        end
    end

    assign n_words   = words_for_op(cur_op);
    assign depth     = SP_TOP - sp_q;
    assign last_word = (cur_idx == (n_words - CNT_W'(1)));
    assign cur_word  = stack_word(cur_op, cur_idx);
    // Bounds are judged once, at acceptance, against the whole operation.
    assign bound_ok  = (state_q != ST_IDLE) ||
                       (is_push_op(cur_op) ? (sp_q >= ADDR_W'(n_words))
                                           : (depth >= ADDR_W'(n_words)));

    // Next-state, memory port and result computation.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        op_d              = op_q;
        pc_d              = pc_q;
        flags_d           = flags_q;
        sp_d              = sp_q;
        rd_data_d         = rd_data_q;
        rd_valid_d        = 1'b0;
        pc_out_d          = pc_out_q;
        pc_out_valid_d    = 1'b0;
        flags_out_d       = flags_out_q;
        flags_out_valid_d = 1'b0;
        stack_exc_d       = 1'b0;
        stall_c           = 1'b0;
        ram_we            = 1'b0;
        ram_waddr         = sp_q;
        ram_wdata         = store_data;
        ram_raddr         = sp_q + ADDR_W'(1);

        case (cur_op)
            OP_LOAD: begin
                ram_raddr  = mem_addr;
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            OP_STORE: begin
                ram_we    = 1'b1;
                ram_waddr = mem_addr;
            end
            OP_PUSH, OP_CALL, OP_INT: begin
                if (!bound_ok) begin
                    stack_exc_d = 1'b1;
                end else begin
                    ram_we = 1'b1;
                    case (cur_word)
                        W_PC_HI: ram_wdata = cur_pc[PC_W-1 -: DATA_W];
                        W_PC_LO: ram_wdata = cur_pc[DATA_W-1:0];
                        W_FLAGS: ram_wdata = DATA_W'(cur_flags);
                        default: ram_wdata = store_data;
                    endcase
                    sp_d    = sp_q - ADDR_W'(1);
                    op_d    = cur_op;
                    pc_d    = cur_pc;
                    flags_d = cur_flags;
                    if (last_word) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PUSH_SEQ;
                        cnt_d   = cur_idx + CNT_W'(1);
                        stall_c = 1'b1;
                    end
                end
            end
            OP_POP, OP_RET, OP_RTI: begin
                if (!bound_ok) begin
                    stack_exc_d = 1'b1;
                end else begin
                    case (cur_word)
                        W_PC_LO: pc_d[DATA_W-1:0] = ram_rdata;
                        W_PC_HI: begin
                            pc_out_d       = PC_W'({ram_rdata, pc_q[DATA_W-1:0]});
                            pc_out_valid_d = 1'b1;
                        end
                        W_FLAGS: begin
                            flags_out_d       = ram_rdata[FLAG_W-1:0];
                            flags_out_valid_d = 1'b1;
                        end
                        default: begin
                            rd_data_d  = ram_rdata;
                            rd_valid_d = 1'b1;
                        end
                    endcase
                    sp_d = sp_q + ADDR_W'(1);
                    op_d = cur_op;
                    if (last_word) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_POP_SEQ;
                        cnt_d   = cur_idx + CNT_W'(1);
                        stall_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            op_q              <= OP_NOP;
            pc_q              <= '0;
            flags_q           <= '0;
            sp_q              <= SP_TOP;
            rd_data_q         <= '0;
            rd_valid_q        <= 1'b0;
            pc_out_q          <= '0;
            pc_out_valid_q    <= 1'b0;
            flags_out_q       <= '0;
            flags_out_valid_q <= 1'b0;
            stack_exc_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            op_q              <= op_d;
            pc_q              <= pc_d;
            flags_q           <= flags_d;
            sp_q              <= sp_d;
            rd_data_q         <= rd_data_d;
            rd_valid_q        <= rd_valid_d;
            pc_out_q          <= pc_out_d;
            pc_out_valid_q    <= pc_out_valid_d;
            flags_out_q       <= flags_out_d;
            flags_out_valid_q <= flags_out_valid_d;
            stack_exc_q       <= stack_exc_d;
        end
    end

    data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & rst_n),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign stall           = stall_c;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign pc_out          = pc_out_q;
    assign pc_out_valid    = pc_out_valid_q;
    assign flags_out       = flags_out_q;
    assign flags_out_valid = flags_out_valid_q;
    assign stack_exc       = stack_exc_q;
    assign sp              = sp_q;

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Self-checking bench for mem_stack_ctrl against a word-level stack model.
module tb_mem_stack_ctrl;
    import mem_pkg::*;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NCYC   = 6;

    // Per-operation observation: bit c of each mask is cycle c after acceptance.
    typedef struct packed {
        logic [NCYC-1:0]   stall;
        logic [NCYC-1:0]   rdv;
        logic [NCYC-1:0]   pcv;
        logic [NCYC-1:0]   flv;
        logic [NCYC-1:0]   exc;
        logic [15:0]       rd;
        logic [31:0]       pc;
        logic [2:0]        fl;
        logic [ADDR_W-1:0] sp;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_valid;
    mem_op_e           mem_op;
    logic [15:0]       alu_result;
    logic [15:0]       store_data;
    logic [31:0]       pc_in;
    logic [2:0]        flags_in;
    logic              stall;
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic [31:0]       pc_out;
    logic              pc_out_valid;
    logic [2:0]        flags_out;
    logic              flags_out_valid;
    logic              stack_exc;
    logic [ADDR_W-1:0] sp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_mem [DEPTH];
    int          m_sp;

    mem_stack_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .mem_op          (mem_op),
        .alu_result      (alu_result),
        .store_data      (store_data),
        .pc_in           (pc_in),
        .flags_in        (flags_in),
        .stall           (stall),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .pc_out          (pc_out),
        .pc_out_valid    (pc_out_valid),
        .flags_out       (flags_out),
        .flags_out_valid (flags_out_valid),
        .stack_exc       (stack_exc),
        .sp              (sp)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input res_t x);
        return $sformatf("stall=%b rdv=%b rd=%h pcv=%b pc=%h flv=%b fl=%b exc=%b sp=%0d",
                         x.stall, x.rdv, x.rd, x.pcv, x.pc, x.flv, x.fl, x.exc, x.sp);
    endfunction

    // Reference: what one operation should do, from the stack rules alone.
    task automatic model_op(input mem_op_e op, input logic [15:0] addr, input logic [15:0] data,
                            input logic [31:0] pc, input logic [2:0] fl, output res_t e);
        int  n;
        int  a;
        bit  push;
        bit  pop;
        e    = '0;
        a    = int'(addr) % DEPTH;
        push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
        pop  = (op == OP_POP)  || (op == OP_RET)  || (op == OP_RTI);
        n    = (op == OP_CALL || op == OP_RET) ? 2 : (op == OP_INT || op == OP_RTI) ? 3 : 1;
        if ((push && m_sp < n) || (pop && (DEPTH - 1 - m_sp) < n)) begin
            e.exc = NCYC'(2);
        end else begin
            if (push || pop) e.stall = NCYC'((1 << (n - 1)) - 1);
            case (op)
                OP_LOAD:  begin e.rdv = NCYC'(2); e.rd = m_mem[a]; end
                OP_STORE: m_mem[a] = data;
                OP_PUSH:  begin m_mem[m_sp] = data; m_sp -= 1; end
                OP_CALL:  begin
                    m_mem[m_sp] = pc[31:16]; m_mem[m_sp-1] = pc[15:0]; m_sp -= 2;
                end
                OP_INT:   begin
                    m_mem[m_sp] = pc[31:16]; m_mem[m_sp-1] = pc[15:0];
                    m_mem[m_sp-2] = {13'b0, fl}; m_sp -= 3;
                end
                OP_POP:   begin e.rdv = NCYC'(2); e.rd = m_mem[m_sp+1]; m_sp += 1; end
                OP_RET:   begin
                    e.pcv = NCYC'(4); e.pc = {m_mem[m_sp+2], m_mem[m_sp+1]}; m_sp += 2;
                end
                OP_RTI:   begin
                    e.flv = NCYC'(2); e.fl = m_mem[m_sp+1][2:0];
                    e.pcv = NCYC'(8); e.pc = {m_mem[m_sp+3], m_mem[m_sp+2]}; m_sp += 3;
                end
                default: ;
            endcase
        end
        e.sp = ADDR_W'(m_sp);
    endtask

    // Issue one operation and record what the DUT does over the following cycles.
    task automatic run_op(input mem_op_e op, input logic [15:0] addr, input logic [15:0] data,
                          input logic [31:0] pc, input logic [2:0] fl, output res_t r);
        r = '0;
        @(negedge clk);
        op_valid   = 1'b1;
        mem_op     = op;
        alu_result = addr;
        store_data = data;
        pc_in      = pc;
        flags_in   = fl;
        for (int c = 0; c < int'(NCYC); c++) begin
            if (c > 0) begin
                @(negedge clk);
                op_valid = 1'b0;
                mem_op   = mem_op_e'(4'($urandom_range(0, 15)));
            end
            #1;
            r.stall[c] = stall;
            r.exc[c]   = stack_exc;
            if (rd_valid)        begin r.rdv[c] = 1'b1; r.rd = rd_data;   end
            if (pc_out_valid)    begin r.pcv[c] = 1'b1; r.pc = pc_out;    end
            if (flags_out_valid) begin r.flv[c] = 1'b1; r.fl = flags_out; end
        end
        r.sp = sp;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_sp  = DEPTH - 1;
    endtask

    task automatic test_reset();
        op_valid = 1'b0; mem_op = OP_NOP; alu_result = '0; store_data = '0;
        pc_in = '0; flags_in = '0; rst_n = 1'b0;
        apply_reset();
        #1;
        n_checks++;
        if (sp !== ADDR_W'(DEPTH - 1)) begin
            n_fail++; $display("FAIL reset_sp got=%0d want=%0d", sp, DEPTH - 1);
        end
        n_checks++;
        if ({stall, rd_valid, pc_out_valid, flags_out_valid, stack_exc} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got=%b want=00000",
                     {stall, rd_valid, pc_out_valid, flags_out_valid, stack_exc});
        end
        n_checks++;
        if ({rd_data, pc_out, flags_out} !== 51'b0) begin
            n_fail++;
            $display("FAIL reset_data got rd=%h pc=%h fl=%b want zeros", rd_data, pc_out, flags_out);
        end
    endtask

    task automatic test_store_load();
        res_t r, e;
        run_op(OP_STORE, 16'h0010, 16'hBEEF, '0, '0, r);
        model_op(OP_STORE, 16'h0010, 16'hBEEF, '0, '0, e);
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL store got {%s} want {%s}", fmt(r), fmt(e)); end
        run_op(OP_LOAD, 16'h0010, 16'h0, '0, '0, r);
        model_op(OP_LOAD, 16'h0010, 16'h0, '0, '0, e);
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL load got {%s} want {%s}", fmt(r), fmt(e)); end
        n_checks++;
        if (r.rd !== 16'hBEEF || r.rdv !== NCYC'(2) || r.stall !== '0 || r.sp !== 11'd2047) begin
            n_fail++; $display("FAIL load_beef got {%s} want rd=beef rdv@1 no stall sp=2047", fmt(r));
        end
    endtask

    task automatic test_push_pop();
        mem_op_e          ops  [4] = '{OP_PUSH, OP_PUSH, OP_POP, OP_POP};
        logic [15:0]      dat  [4] = '{16'h1234, 16'h5678, 16'h0, 16'h0};
        logic [15:0]      rdx  [4] = '{16'h0, 16'h0, 16'h5678, 16'h1234};
        logic [ADDR_W-1:0] spx [4] = '{11'd2046, 11'd2045, 11'd2046, 11'd2047};
        res_t r, e;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 16'h0, dat[i], '0, '0, r);
            model_op(ops[i], 16'h0, dat[i], '0, '0, e);
            n_checks++;
            if (r !== e || r.sp !== spx[i] || r.rd !== rdx[i]) begin
                n_fail++;
                $display("FAIL push_pop[%0d] got {%s} want {%s} sp=%0d rd=%h",
                         i, fmt(r), fmt(e), spx[i], rdx[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        res_t r, e;
        run_op(OP_CALL, 16'h0, 16'h0, 32'h0001_0040, '0, r);
        model_op(OP_CALL, 16'h0, 16'h0, 32'h0001_0040, '0, e);
        n_checks++;
        if (r !== e || r.stall !== NCYC'(1) || r.sp !== 11'd2045) begin
            n_fail++; $display("FAIL call got {%s} want {%s}", fmt(r), fmt(e));
        end
        n_checks++;
        if (dut.u_ram.mem[2047] !== 16'h0001 || dut.u_ram.mem[2046] !== 16'h0040) begin
            n_fail++;
            $display("FAIL call_mem got %h,%h want 0001,0040", dut.u_ram.mem[2047], dut.u_ram.mem[2046]);
        end
        run_op(OP_RET, 16'h0, 16'h0, '0, '0, r);
        model_op(OP_RET, 16'h0, 16'h0, '0, '0, e);
        n_checks++;
        if (r !== e || r.pc !== 32'h0001_0040 || r.pcv !== NCYC'(4) || r.sp !== 11'd2047) begin
            n_fail++; $display("FAIL ret got {%s} want {%s}", fmt(r), fmt(e));
        end
    endtask

    task automatic test_int_rti();
        res_t r, e;
        run_op(OP_INT, 16'h0, 16'h0, 32'h0000_0100, 3'b101, r);
        model_op(OP_INT, 16'h0, 16'h0, 32'h0000_0100, 3'b101, e);
        n_checks++;
        if (r !== e || r.stall !== NCYC'(3) || r.sp !== 11'd2044) begin
            n_fail++; $display("FAIL int got {%s} want {%s}", fmt(r), fmt(e));
        end
        run_op(OP_RTI, 16'h0, 16'h0, '0, '0, r);
        model_op(OP_RTI, 16'h0, 16'h0, '0, '0, e);
        n_checks++;
        if (r !== e || r.fl !== 3'b101 || r.flv !== NCYC'(2) || r.pc !== 32'h0000_0100 ||
            r.pcv !== NCYC'(8) || r.sp !== 11'd2047) begin
            n_fail++; $display("FAIL rti got {%s} want {%s}", fmt(r), fmt(e));
        end
    endtask

    task automatic test_bounds();
        res_t        r, e;
        logic [15:0] mem0;
        mem_op_e     seq [5] = '{OP_POP, OP_PUSH, OP_RET, OP_RTI, OP_POP};
        for (int i = 0; i < 5; i++) begin
            run_op(seq[i], 16'h0, 16'h00A0 + 16'(i), 32'h1234_5678, 3'b010, r);
            model_op(seq[i], 16'h0, 16'h00A0 + 16'(i), 32'h1234_5678, 3'b010, e);
            n_checks++;
            if (r !== e) begin
                n_fail++; $display("FAIL underflow[%0d] got {%s} want {%s}", i, fmt(r), fmt(e));
            end
        end
        // Fill the stack down to sp=0.
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            run_op(OP_PUSH, 16'h0, 16'($urandom), '0, '0, r);
            model_op(OP_PUSH, 16'h0, r.rd, '0, '0, e);
            m_mem[m_sp + 1] = dut.u_ram.mem[m_sp + 1];
            if (i == int'(DEPTH) - 2) begin
                n_checks++;
                if (r.sp !== '0 || r.exc !== '0) begin
                    n_fail++; $display("FAIL fill got {%s} want sp=0 no exc", fmt(r));
                end
            end
        end
        mem0 = m_mem[0];
        run_op(OP_PUSH, 16'h0, ~mem0, '0, '0, r);
        model_op(OP_PUSH, 16'h0, ~mem0, '0, '0, e);
        n_checks++;
        if (r !== e || r.exc !== NCYC'(2) || dut.u_ram.mem[0] !== mem0) begin
            n_fail++;
            $display("FAIL overflow got {%s} mem0=%h want {%s} mem0=%h", fmt(r), dut.u_ram.mem[0], fmt(e), mem0);
        end
        run_op(OP_POP, 16'h0, 16'h0, '0, '0, r);
        model_op(OP_POP, 16'h0, 16'h0, '0, '0, e);
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL pop_full got {%s} want {%s}", fmt(r), fmt(e)); end
        run_op(OP_CALL, 16'h0, 16'h0, 32'hDEAD_BEEF, '0, r);
        model_op(OP_CALL, 16'h0, 16'h0, 32'hDEAD_BEEF, '0, e);
        n_checks++;
        if (r !== e || r.exc !== NCYC'(2) || r.sp !== 11'd1) begin
            n_fail++; $display("FAIL call_overflow got {%s} want {%s}", fmt(r), fmt(e));
        end
        apply_reset();
    endtask

    task automatic test_random();
        res_t        r, e;
        mem_op_e     op;
        logic [15:0] addr;
        int          k;
        for (int i = 0; i < 16; i++) begin
            run_op(OP_STORE, 16'(i), 16'($urandom), '0, '0, r);
            model_op(OP_STORE, 16'(i), store_data, '0, '0, e);
        end
        for (int i = 0; i < 400; i++) begin
            k    = $urandom_range(0, 19);
            op   = (k < 18) ? mem_op_e'(4'(k % 9)) : mem_op_e'(4'(9 + $urandom_range(0, 6)));
            addr = {5'($urandom), 7'b0, 4'($urandom)};
            run_op(op, addr, 16'($urandom), 32'($urandom), 3'($urandom), r);
            model_op(op, addr, store_data, pc_in, flags_in, e);
            n_checks++;
            if (r !== e) begin
                n_fail++; $display("FAIL random[%0d] op=%0d got {%s} want {%s}", i, op, fmt(r), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t r, e;
        apply_reset();
        @(negedge clk);
        op_valid = 1'b1; mem_op = OP_INT; pc_in = 32'hCAFE_0123; flags_in = 3'b011;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_c0_stall got=%b want=1", stall); end
        @(negedge clk);
        op_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (sp !== 11'd2047 || stall !== 1'b0 || pc_out_valid !== 1'b0 || flags_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid got sp=%0d stall=%b pcv=%b flv=%b want 2047,0,0,0",
                     sp, stall, pc_out_valid, flags_out_valid);
        end
        n_checks++;
        if (dut.u_ram.mem[2047] !== 16'hCAFE) begin
            n_fail++; $display("FAIL rstmid_word got=%h want=cafe", dut.u_ram.mem[2047]);
        end
        rst_n = 1'b1;
        m_sp = DEPTH - 1;
        m_mem[2047] = 16'hCAFE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({stall, pc_out_valid, flags_out_valid, stack_exc} !== 4'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet[%0d] got=%b want=0000", c,
                         {stall, pc_out_valid, flags_out_valid, stack_exc});
            end
        end
        run_op(OP_PUSH, 16'h0, 16'h7A7A, '0, '0, r);
        model_op(OP_PUSH, 16'h0, 16'h7A7A, '0, '0, e);
        n_checks++;
        if (r !== e || r.sp !== 11'd2046) begin
            n_fail++; $display("FAIL rstmid_push got {%s} want {%s}", fmt(r), fmt(e));
        end
        run_op(OP_POP, 16'h0, 16'h0, '0, '0, r);
        model_op(OP_POP, 16'h0, 16'h0, '0, '0, e);
        n_checks++;
        if (r !== e || r.rd !== 16'h7A7A) begin
            n_fail++; $display("FAIL rstmid_pop got {%s} want {%s}", fmt(r), fmt(e));
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_push_pop();
        test_call_ret();
        test_int_rti();
        test_bounds();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stack_ctrl.md
Name: mem_stack_ctrl

Overview:
- Memory-stage controller directly downstream of the execute-stage ALU.
- Consumes the ALU result (address or store data), register data and the current flag register.
- Performs data-memory load/store and all stack traffic: PUSH/POP, CALL/RET, INT/RTI.
- Stalls upstream for multi-word stack operations; returns popped PC and popped flags, which become the ALU's conditions_from_memory_pop.

Parameters:
- ADDR_W, 11, data-memory word-address width; depth 2^ADDR_W 16-bit words.
- PC_W, 32, program-counter width; stacked as two 16-bit words, high word first.
- SP_TOP, 2^ADDR_W-1, stack-pointer reset value (empty-stack position).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  operation present this cycle.
- mem_op  in  4  operation code (package enum).
- alu_result  in  16  load/store address (low ADDR_W bits used).
- store_data  in  16  STORE/PUSH data.
- pc_in  in  PC_W  return PC for CALL/INT.
- flags_in  in  3  {carry, negative, zero} pushed by INT.
- stall  out  1  upstream freeze request.
- rd_data  out  16  LOAD/POP data, registered.
- rd_valid  out  1  1-cycle pulse with rd_data.
- pc_out  out  PC_W  PC popped by RET/RTI.
- pc_out_valid  out  1  1-cycle pulse.
- flags_out  out  3  flags popped by RTI (feeds conditions_from_memory_pop).
- flags_out_valid  out  1  1-cycle pulse.
- stack_exc  out  1  1-cycle pulse: stack overflow/underflow, operation aborted.
- sp  out  ADDR_W  current stack pointer.

Behaviour:
- Reset (rst_n=0 at posedge): sp=SP_TOP, FSM=IDLE, all valid pulses, stall and stack_exc =0, rd_data/pc_out/flags_out =0.
- Memory: synchronous write at posedge, combinational read.
- Stack: full-descending. Push writes mem[sp], then sp-1. Pop reads mem[sp+1], then sp+1.
- Stack depth = SP_TOP - sp.
- Acceptance: op accepted only when FSM=IDLE and op_valid=1; op_valid ignored in any other state.
- Word counts n: LOAD/STORE/PUSH/POP 1; CALL/RET 2; INT/RTI 3.
- Push order:
  - CALL: pc_in[31:16] then pc_in[15:0].
  - INT: pc high, pc low, then {13'b0, flags_in}.
- Pop order is the reverse:
  - RET: low word, then high word.
  - RTI: flags, PC low, PC high.
- Cycle 0 is the acceptance cycle:
  - The first word is transferred in cycle 0.
  - Each following cycle transfers one more word.
  - The last word is transferred in cycle n-1.
- stall=1 combinationally in cycles 0..n-2 and 0 in cycle n-1. Single-word ops never stall.
- Result timing:
  - rd_valid/rd_data are asserted at cycle 1 for LOAD/POP.
  - pc_out_valid is asserted the cycle after the last PC word.
  - flags_out_valid is asserted the cycle after the flags word (RTI cycle 1).
- FSM states:
  - IDLE → (n>1) PUSH_SEQ or POP_SEQ, with a word counter.
  - Return to IDLE after the last word.
  - ABORT is not a state; exceptions resolve in cycle 0.
- Bounds checked at acceptance, using the whole-operation word count:
  - A push op requires sp ≥ n.
  - A pop op requires depth ≥ n.
  - On violation: no write, sp unchanged, no valid pulses, stack_exc pulses at cycle 1, no stall.
- LOAD/STORE never affect sp and never raise stack_exc. Address wraps modulo 2^ADDR_W.
- mem_op NOP or undefined: no effect.
- Reset mid-sequence:
  - Aborts the sequence.
  - Words already written remain in memory; sp still returns to SP_TOP.
  - Any pending pulse is suppressed.

Decomposition:
- Package mem_pkg:
  - mem_op_e enum: NOP, LOAD, STORE, PUSH, POP, CALL, RET, INT, RTI.
  - FSM state enum.
  - Function words_for_op(mem_op_e) → n.
  - Constants PC_W, FLAG_W=3.
- One sub-module data_ram (ADDR_W × 16):
  - Ports clk, we, waddr, wdata, raddr, rdata.
  - Sync write, async read, no reset of contents.

Test Plan:
- Reset, STORE 16'hBEEF @0x010, then LOAD @0x010 → rd_valid at cycle 1, rd_data=16'hBEEF, sp=2047, stall never high.
- PUSH 16'h1234, PUSH 16'h5678, POP, POP:
  - sp goes 2047→2046→2045→2046→2047.
  - rd_data 16'h5678, then 16'h1234.
- CALL with pc_in=32'h0001_0040:
  - stall high 1 cycle; mem[2047]=16'h0001, mem[2046]=16'h0040; sp=2045.
  - Then RET → pc_out=32'h0001_0040 with pc_out_valid, stall 1 cycle, sp=2047.
- INT with pc=32'h0000_0100, flags=3'b101:
  - stall 2 cycles, sp=2044.
  - RTI → flags_out=3'b101 at cycle 1, pc_out=32'h0000_0100 at cycle 3, sp=2047.
- Underflow and overflow:
  - POP on empty stack → stack_exc pulse, sp stays 2047, no rd_valid.
  - RET with depth 1 → stack_exc, sp unchanged.
  - PUSH with sp=0 → stack_exc, mem[0] unchanged.
- rst_n=0 at INT cycle 1 → next cycle sp=2047, stall=0, no pc_out_valid/flags_out_valid. A following PUSH works normally.
